// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encrypt block: top-level state
// enum, per-step sub-state enum and the key byte selector.
package arc4_pkg;

   localparam int SBOX_SIZE = 256;
   localparam int KEY_BYTES = 3;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      KSA,
      LEN,
      PRGA
   } arc4_enc_state_t;

   // Sub-steps shared by KSA (RDI..WRJ) and PRGA (RDI..OUT).
   typedef enum logic [2:0] {
      SUB_RDI,
      SUB_RDJ,
      SUB_WRI,
      SUB_WRJ,
      SUB_RDP,
      SUB_OUT
   } arc4_sub_t;

   // Key byte 0 lives in key[23:16].
   function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx);
      logic [7:0] kb;
      case (idx % 8'(KEY_BYTES))
         8'd0:    kb = key[23:16];
         8'd1:    kb = key[15:8];
         default: kb = key[7:0];
      endcase
      return kb;
   endfunction

endpackage

// File: rtl/arc4_sbox.sv
// 256x8 single-port ARC4 state RAM: synchronous write, registered read.
// Contents are not reset; the encrypt FSM rewrites every entry each run.
module arc4_sbox #(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic [7:0] addr,
   input  logic [7:0] wrdata,
   input  logic       wren,
   output logic [7:0] rddata
);

   logic [7:0] mem [256];

   always_ff @(posedge clk) begin
      if (wren) begin
         mem[addr] <= wrdata;
      end
   end

   // Only the single-cycle read pipeline exists.
   if (MEM_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
         rddata <= mem[addr];
      end
   end else begin : g_lat_unsupported
      assign rddata = 8'h00;
   end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryption of a length-prefixed plaintext into the ciphertext memory.
// Define ARC4_ENC_CHECKSUM_EN to add the ct_csum XOR-of-ciphertext output.
module arc4_encrypt #(
   parameter int KEY_BYTES = 3,
   parameter int MEM_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata,
   output logic [7:0]  ct_addr,
   output logic [7:0]  ct_wrdata,
   output logic        ct_wren
`ifdef ARC4_ENC_CHECKSUM_EN
   ,
   output logic [7:0]  ct_csum
`endif
);

   import arc4_pkg::*;

   arc4_enc_state_t state_q, state_d;
   arc4_sub_t       sub_q, sub_d;
   logic [7:0]      i_q, i_d;
   logic [7:0]      j_q, j_d;
   logic [7:0]      si_q, si_d;
   logic [7:0]      sj_q, sj_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      pt_addr_q, pt_addr_d;
   logic [23:0]     key_q, key_d;

   logic [7:0]      sb_addr;
   logic [7:0]      sb_wrdata;
   logic            sb_wren;
   logic [7:0]      sb_rddata;

   arc4_sbox #(
      .MEM_LAT (MEM_LAT)
   ) u_sbox (
      .clk    (clk),
      .addr   (sb_addr),
      .wrdata (sb_wrdata),
      .wren   (sb_wren),
      .rddata (sb_rddata)
   );

   assign pt_addr = pt_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sub_q     <= SUB_RDI;
         i_q       <= 8'h00;
         j_q       <= 8'h00;
         si_q      <= 8'h00;
         sj_q      <= 8'h00;
         len_q     <= 8'h00;
         pt_addr_q <= 8'h00;
         key_q     <= 24'h000000;
      end else begin
         state_q   <= state_d;
         sub_q     <= sub_d;
         i_q       <= i_d;
         j_q       <= j_d;
         si_q      <= si_d;
         sj_q      <= sj_d;
         len_q     <= len_d;
         pt_addr_q <= pt_addr_d;
         key_q     <= key_d;
      end
   end

   // Every S-box read is issued one step before its data is consumed.
   // pt_addr is held on the current byte, so pt_rddata is stable by SUB_OUT.
   always_comb begin
      state_d   = state_q;
      sub_d     = sub_q;
      i_d       = i_q;
      j_d       = j_q;
      si_d      = si_q;
      sj_d      = sj_q;
      len_d     = len_q;
      pt_addr_d = pt_addr_q;
      key_d     = key_q;
      sb_addr   = 8'h00;
      sb_wrdata = 8'h00;
      sb_wren   = 1'b0;
      rdy       = 1'b0;
      ct_wren   = 1'b0;
      ct_addr   = 8'h00;
      ct_wrdata = 8'h00;

      case (state_q)
         IDLE: begin
            rdy = 1'b1;
            if (en) begin
               key_d     = key;
               i_d       = 8'h00;
               pt_addr_d = 8'h00;
               state_d   = INIT;
            end
         end

         INIT: begin
            sb_addr   = i_q;
            sb_wrdata = i_q;
            sb_wren   = 1'b1;
            i_d       = i_q + 8'd1;
            if (i_q == 8'(SBOX_SIZE - 1)) begin
               j_d     = 8'h00;
               sub_d   = SUB_RDI;
               state_d = KSA;
            end
         end

         KSA: begin
            case (sub_q)
               SUB_RDI: begin
                  sb_addr = i_q;
                  sub_d   = SUB_RDJ;
               end
               SUB_RDJ: begin
                  si_d    = sb_rddata;
                  j_d     = j_q + sb_rddata + key_byte(key_q, 8'(i_q % 8'(KEY_BYTES)));
                  sb_addr = j_d;
                  sub_d   = SUB_WRI;
               end
               SUB_WRI: begin
                  sj_d      = sb_rddata;
                  sb_addr   = i_q;
                  sb_wrdata = sb_rddata;
                  sb_wren   = 1'b1;
                  sub_d     = SUB_WRJ;
               end
               SUB_WRJ: begin
                  sb_addr   = j_q;
                  sb_wrdata = si_q;
                  sb_wren   = 1'b1;
                  i_d       = i_q + 8'd1;
                  sub_d     = SUB_RDI;
                  if (i_q == 8'(SBOX_SIZE - 1)) begin
                     state_d = LEN;
                  end
               end
               default: begin
                  sub_d = SUB_RDI;
               end
            endcase
         end

         LEN: begin
            len_d     = pt_rddata;
            ct_wren   = 1'b1;
            ct_addr   = 8'h00;
            ct_wrdata = pt_rddata;
            i_d       = 8'h00;
            j_d       = 8'h00;
            sub_d     = SUB_RDI;
            if (pt_rddata == 8'h00) begin
               state_d = IDLE;
            end else begin
               pt_addr_d = 8'h01;
               state_d   = PRGA;
            end
         end

         PRGA: begin
            case (sub_q)
               SUB_RDI: begin
                  i_d     = i_q + 8'd1;
                  sb_addr = i_d;
                  sub_d   = SUB_RDJ;
               end
               SUB_RDJ: begin
                  si_d    = sb_rddata;
                  j_d     = j_q + sb_rddata;
                  sb_addr = j_d;
                  sub_d   = SUB_WRI;
               end
               SUB_WRI: begin
                  sj_d      = sb_rddata;
                  sb_addr   = i_q;
                  sb_wrdata = sb_rddata;
                  sb_wren   = 1'b1;
                  sub_d     = SUB_WRJ;
               end
               SUB_WRJ: begin
                  sb_addr   = j_q;
                  sb_wrdata = si_q;
                  sb_wren   = 1'b1;
                  sub_d     = SUB_RDP;
               end
               SUB_RDP: begin
                  sb_addr = si_q + sj_q;
                  sub_d   = SUB_OUT;
               end
               SUB_OUT: begin
                  ct_wren   = 1'b1;
                  ct_addr   = pt_addr_q;
                  ct_wrdata = pt_rddata ^ sb_rddata;
                  sub_d     = SUB_RDI;
                  // Stopping on k == len keeps ct_addr from wrapping at len=255.
                  if (pt_addr_q == len_q) begin
                     state_d = IDLE;
                  end else begin
                     pt_addr_d = pt_addr_q + 8'd1;
                  end
               end
               default: begin
                  sub_d = SUB_RDI;
               end
            endcase
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef ARC4_ENC_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == IDLE && en) begin
         csum_d = 8'h00;
      end else if (ct_wren) begin
         csum_d = csum_q ^ ct_wrdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= 8'h00;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign ct_csum = csum_q;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt: table of directed runs checked against
// a software ARC4 model, plus round-trip and mid-run reset sequences.
module tb_arc4_encrypt;

   logic        clk;
   logic        rst;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  pt_addr;
   logic [7:0]  pt_rddata;
   logic [7:0]  ct_addr;
   logic [7:0]  ct_wrdata;
   logic        ct_wren;
`ifdef ARC4_ENC_CHECKSUM_EN
   logic [7:0]  ct_csum;
`endif

   arc4_encrypt dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .rdy       (rdy),
      .key       (key),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .ct_addr   (ct_addr),
      .ct_wrdata (ct_wrdata),
      .ct_wren   (ct_wren)
`ifdef ARC4_ENC_CHECKSUM_EN
      ,
      .ct_csum   (ct_csum)
`endif
   );

   typedef struct {
      logic [23:0] key;
      int          len;
      int          pattern;
      int          expWrites;
      logic [7:0]  expLast;
   } vec_t;

   logic [7:0] pt_mem   [256];
   logic [7:0] ct_mem   [256];
   logic [7:0] exp_ct   [256];
   logic [7:0] first_ct [256];
   logic [7:0] hello    [5];

   int         total;
   int         bad;
   int         wr_count;
   int         next_addr;
   int         order_err;
   logic [7:0] last_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read plaintext memory.
   always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic observe();
      if (ct_wren === 1'b1) begin
         ct_mem[ct_addr] = ct_wrdata;
         if (int'(ct_addr) != next_addr) order_err++;
         next_addr++;
         wr_count++;
         last_addr = ct_addr;
      end
   endtask

   task automatic clearLog();
      wr_count  = 0;
      next_addr = 0;
      order_err = 0;
      last_addr = 8'h00;
      for (int x = 0; x < 256; x++) ct_mem[x] = 8'hxx;
   endtask

   task automatic loadPattern(input int pattern, input int len);
      for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;
      pt_mem[0] = 8'(len);
      for (int x = 1; x <= len; x++) begin
         case (pattern)
            0:       pt_mem[x] = hello[x-1];
            2:       pt_mem[x] = 8'(x * 7 + 3);
            default: pt_mem[x] = 8'hA5 ^ 8'(x);
         endcase
      end
   endtask

   function automatic void arc4Model(input logic [23:0] k);
      logic [7:0] s [256];
      logic [7:0] kb [3];
      logic [7:0] i8, j8, t, idx;
      int         n;
      kb[0] = k[23:16];
      kb[1] = k[15:8];
      kb[2] = k[7:0];
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      j8 = 8'h00;
      for (int x = 0; x < 256; x++) begin
         j8    = j8 + s[x] + kb[x % 3];
         t     = s[x];
         s[x]  = s[j8];
         s[j8] = t;
      end
      n = int'(pt_mem[0]);
      exp_ct[0] = pt_mem[0];
      i8 = 8'h00;
      j8 = 8'h00;
      for (int x = 1; x <= n; x++) begin
         i8        = i8 + 8'd1;
         j8        = j8 + s[i8];
         t         = s[i8];
         s[i8]     = s[j8];
         s[j8]     = t;
         idx       = s[i8] + s[j8];
         exp_ct[x] = pt_mem[x] ^ s[idx];
      end
   endfunction

   task automatic applyStimulus(input logic [23:0] k, input int limit, output int cycles, output bit tmo);
      int w;
      w = 0;
      while (rdy !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      en  = 1'b1;
      key = k;
      @(posedge clk);
      #1;
      en  = 1'b0;
      key = ~k;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         observe();
         if (cycles == 40) en = 1'b1;
         if (cycles == 41) en = 1'b0;
      end while (rdy !== 1'b1 && cycles < limit);
      tmo = (rdy !== 1'b1);
   endtask

   task automatic runCase(input vec_t v, input string name);
      int cycles, mism, bound;
      bit tmo;
      loadPattern(v.pattern, v.len);
      arc4Model(v.key);
      clearLog();
      bound = 256 + 1280 + 3 + 8 * v.len;
      applyStimulus(v.key, bound + 8, cycles, tmo);
      checkOutput($sformatf("%s done", name), 32'(tmo), 32'd0);
      checkOutput($sformatf("%s writes", name), wr_count, v.expWrites);
      checkOutput($sformatf("%s last_addr", name), 32'(last_addr), 32'(v.expLast));
      checkOutput($sformatf("%s order", name), order_err, 0);
      checkOutput($sformatf("%s ct0", name), 32'(ct_mem[0]), v.len);
      mism = 0;
      for (int x = 0; x <= v.len; x++) if (ct_mem[x] !== exp_ct[x]) mism++;
      checkOutput($sformatf("%s ct_bytes_mismatched", name), mism, 0);
      checkOutput($sformatf("%s within_bound", name), 32'(cycles <= bound), 32'd1);
      checkOutput($sformatf("%s rdy", name), 32'(rdy), 32'd1);
   endtask

   initial begin
      vec_t vecs [4];
      int   cycles, n, mism;
      bit   tmo;
      logic [7:0] xsum;

      total = 0;
      bad   = 0;
      hello[0] = 8'h68; hello[1] = 8'h65; hello[2] = 8'h6c; hello[3] = 8'h6c; hello[4] = 8'h6f;
      vecs[0] = '{key: 24'h000018, len: 5,   pattern: 0, expWrites: 6,   expLast: 8'h05};
      vecs[1] = '{key: 24'hFFFFFF, len: 0,   pattern: 1, expWrites: 1,   expLast: 8'h00};
      vecs[2] = '{key: 24'h1E4600, len: 255, pattern: 2, expWrites: 256, expLast: 8'hFF};
      vecs[3] = '{key: 24'h123456, len: 17,  pattern: 3, expWrites: 18,  expLast: 8'h11};

      for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;
      clearLog();
      rst = 1'b1;
      en  = 1'b0;
      key = 24'h000000;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset rdy", 32'(rdy), 32'd1);
      checkOutput("reset ct_wren", 32'(ct_wren), 32'd0);
      checkOutput("reset pt_addr", 32'(pt_addr), 32'd0);
      checkOutput("reset ct_addr", 32'(ct_addr), 32'd0);
      checkOutput("reset ct_wrdata", 32'(ct_wrdata), 32'd0);
`ifdef ARC4_ENC_CHECKSUM_EN
      checkOutput("reset ct_csum", 32'(ct_csum), 32'd0);
`endif

      for (int v = 0; v < 4; v++) begin
         runCase(vecs[v], $sformatf("vec%0d", v));
         if (v == 0) begin
            for (int x = 0; x < 256; x++) first_ct[x] = ct_mem[x];
`ifdef ARC4_ENC_CHECKSUM_EN
            xsum = 8'h00;
            for (int x = 0; x <= 5; x++) xsum = xsum ^ exp_ct[x];
            checkOutput("vec0 ct_csum", 32'(ct_csum), 32'(xsum));
`endif
            // Decrypting the ciphertext image must give back "hello".
            for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;
            for (int x = 0; x <= 5; x++) pt_mem[x] = first_ct[x];
            clearLog();
            applyStimulus(24'h000018, 256 + 1280 + 3 + 40 + 8, cycles, tmo);
            checkOutput("roundtrip done", 32'(tmo), 32'd0);
            checkOutput("roundtrip ct0", 32'(ct_mem[0]), 32'h05);
            for (int x = 1; x <= 5; x++)
               checkOutput($sformatf("roundtrip ct%0d", x), 32'(ct_mem[x]), 32'(hello[x-1]));
         end
      end

      // Reset in the middle of the key schedule.
      loadPattern(0, 5);
      clearLog();
      @(negedge clk);
      en  = 1'b1;
      key = 24'h000018;
      @(posedge clk);
      #1 en = 1'b0;
      repeat (400) begin
         @(negedge clk);
         observe();
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      observe();
      checkOutput("ksa_reset rdy", 32'(rdy), 32'd1);
      checkOutput("ksa_reset ct_wren", 32'(ct_wren), 32'd0);
`ifdef ARC4_ENC_CHECKSUM_EN
      checkOutput("ksa_reset ct_csum", 32'(ct_csum), 32'd0);
`endif
      repeat (20) begin
         @(negedge clk);
         observe();
      end
      checkOutput("ksa_reset writes", wr_count, 0);

      // Reset during PRGA after three ciphertext writes.
      clearLog();
      en  = 1'b1;
      key = 24'h000018;
      @(posedge clk);
      #1 en = 1'b0;
      n = 0;
      while (wr_count < 3 && n < 3000) begin
         @(negedge clk);
         observe();
         n++;
      end
      checkOutput("prga_reset reached", wr_count, 3);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      observe();
      checkOutput("prga_reset rdy", 32'(rdy), 32'd1);
      checkOutput("prga_reset ct_wren", 32'(ct_wren), 32'd0);
      repeat (30) begin
         @(negedge clk);
         observe();
      end
      checkOutput("prga_reset writes", wr_count, 3);

      runCase(vecs[0], "fresh");
      mism = 0;
      for (int x = 0; x <= 5; x++) if (ct_mem[x] !== first_ct[x]) mism++;
      checkOutput("fresh matches_first", mism, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- Encrypts a length-prefixed plaintext message with ARC4 under a 24-bit key.
- Writes the length-prefixed ciphertext into the ciphertext memory that the crack engine later reads.
- Reads plaintext from a 256x8 synchronous-read memory and writes ciphertext to a 256x8 memory.
- Holds the 256-byte ARC4 state in a private S-box sub-module.

Parameters:
- KEY_BYTES, 3, number of key bytes taken from key; the key schedule uses index i mod KEY_BYTES.
- MEM_LAT, 1, plaintext and S-box read latency in cycles; only 1 is supported.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  start request; sampled only while rdy=1.
- rdy  output  1  high when idle and able to accept en.
- key  input  24  ARC4 key; key[23:16] is key byte 0; sampled on the accepted en.
- pt_addr  output  8  plaintext read address.
- pt_rddata  input  8  plaintext data, valid one cycle after pt_addr.
- ct_addr  output  8  ciphertext write address.
- ct_wrdata  output  8  ciphertext write data.
- ct_wren  output  1  ciphertext write strobe, one cycle per byte.

Behaviour:
- Reset: synchronous, active-high; one clk edge with rst=1 is enough.
  - Outputs after reset: rdy=1, ct_wren=0, pt_addr=0, ct_addr=0, ct_wrdata=0.
  - A reset mid-operation aborts immediately: no further writes, state returns to IDLE.
  - S-box contents are don't-care after reset; INIT rewrites them every run.
- Handshake:
  - en is accepted when en=1 && rdy=1; rdy drops the next cycle.
  - key is latched on acceptance; later key changes are ignored.
  - en while rdy=0 is ignored.
  - rdy returns to 1 the cycle after the final ct write.
  - en asserted in that same cycle starts a new run.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> IDLE.
  - INIT: S[i]=i for i=0..255; one write per cycle; 256 cycles.
  - KSA, for i=0..255: j = j + S[i] + key_byte[i mod 3] (mod 256), then swap S[i] and S[j].
    - Sub-steps: read S[i], compute j, read S[j], write both.
    - At most 5 cycles per i.
    - i=j is legal; the swap writes the same value twice with no corruption.
  - LEN: read pt[0] into len. Write ct[0]=len unencrypted (ct_wren pulse, ct_addr=0).
  - PRGA: i=j=0 at entry. For k=1..len:
    - i=i+1; j=j+S[i]; swap S[i], S[j].
    - pad = S[(S[i]+S[j]) mod 256].
    - Write ct[k] = pt[k] ^ pad.
    - At most 8 cycles per byte.
    - Exactly one ct_wren per k, written in ascending address order.
- Arithmetic: all index sums are 8-bit and wrap mod 256.
  - len=255 writes ct[1..255]; ct_addr never wraps to 0 during PRGA.
  - len=0 skips PRGA: exactly one write, ct[0]=0, then IDLE.
- Total run length is at most 256 + 256*5 + 3 + 8*len cycles.
- The ciphertext memory is write-only from this block; ct_addr and ct_wrdata are don't-care when ct_wren=0.

Optional Feature:
- Macro: ARC4_ENC_CHECKSUM_EN.
- Defined:
  - Adds output port ct_csum [7:0], the XOR of all ciphertext bytes written (including ct[0]).
  - Cleared on the accepted en, and to 0 on reset.
  - Valid and stable while rdy=1 after a run.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package arc4_pkg holds:
  - state enum arc4_enc_state_t (IDLE, INIT, KSA, LEN, PRGA);
  - constants SBOX_SIZE=256 and KEY_BYTES=3;
  - function key_byte(key, idx), returning the byte for idx mod 3.
- Sub-module arc4_sbox:
  - 256x8 single-port RAM, synchronous write, 1-cycle registered read;
  - ports clk, addr, wrdata, wren, rddata;
  - instantiated once in arc4_encrypt.

Test Plan:
- Reset, then pulse en with key=24'h000018 and pt="\x05hello" -> exactly 6 ct_wren pulses at addresses 0..5; ct[0]=8'h05; ct[1..5] match the ARC4 software model; rdy back to 1.
- Round trip: load the previous ct image as pt with the same key -> ct[1..5] equals "hello" (68 65 6c 6c 6f).
- pt[0]=8'h00, key=24'hFFFFFF -> single write ct[0]=8'h00; rdy=1 within 256+1280+4 cycles of acceptance.
- pt[0]=8'hFF, key=24'h1E4600 -> 256 writes, last at ct_addr=8'hFF; no write to address 0 after the first; bytes match the model.
- Assert rst mid-KSA, then mid-PRGA after 3 writes:
  - next cycle rdy=1, ct_wren=0;
  - a fresh run with key=24'h000018 produces the same ct as the first scenario;
  - en pulses while rdy=0 are ignored.
- With ARC4_ENC_CHECKSUM_EN defined, the first scenario's stimulus -> ct_csum equals the XOR of ct[0..5] from the model; ct_csum=0 after rst.
